// File: rtl/sram_responder_pkg.sv
// Shared constants for the SRAM responder: MMIO base and register offsets, plus the
// byte-lane merge helper used by the RAM and the MMIO registers.
package sram_responder_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hBFAF_0000;

  localparam logic [15:0] LED_OFF     = 16'h0000;
  localparam logic [15:0] TIMER_OFF   = 16'h0004;
  localparam logic [15:0] SCRATCH_OFF = 16'h0008;
  localparam logic [15:0] RDCNT_OFF   = 16'h0010;
  localparam logic [15:0] WRCNT_OFF   = 16'h0014;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  wen);
    logic [31:0] result;
    for (int i = 0; i < 4; i++) begin
      result[8*i +: 8] = wen[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/sram_responder_mmio.sv
// MMIO register block: LED, free-running TIMER, SCRATCH and, when SRAM_RESPONDER_STATS_EN
// is defined, saturating data-port read/write counters. Read data is combinational.
module sram_responder_mmio
  import sram_responder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        data_en,
  input  logic        mmio_sel,
  input  logic [3:0]  wen,
  input  logic [15:0] offset,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [15:0] led
);

  logic [15:0] led_q;
  logic [31:0] timer_q;
  logic [31:0] scratch_q;
  logic        mmio_wr;
  logic [31:0] led_merged;
  logic [31:0] scratch_merged;

  assign mmio_wr        = data_en & mmio_sel & (|wen);
  // Only lanes 0-1 exist in the LED register.
  assign led_merged     = merge_bytes({16'h0000, led_q}, wdata, {2'b00, wen[1:0]});
  assign scratch_merged = merge_bytes(scratch_q, wdata, wen);

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q     <= '0;
      timer_q   <= '0;
      scratch_q <= '0;
    end else begin
      timer_q <= timer_q + 32'd1;
      if (mmio_wr && offset == LED_OFF)     led_q     <= led_merged[15:0];
      if (mmio_wr && offset == SCRATCH_OFF) scratch_q <= scratch_merged;
    end
  end

`ifdef SRAM_RESPONDER_STATS_EN
  logic [31:0] rdcnt_q;
  logic [31:0] wrcnt_q;

  // Counters cover every data-port access, RAM or MMIO.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdcnt_q <= '0;
      wrcnt_q <= '0;
    end else begin
      if (data_en && wen == 4'b0000 && rdcnt_q != '1) rdcnt_q <= rdcnt_q + 32'd1;
      if (data_en && wen != 4'b0000 && wrcnt_q != '1) wrcnt_q <= wrcnt_q + 32'd1;
    end
  end
`endif

  always_comb begin
    rdata = '0;
    case (offset)
      LED_OFF:     rdata = {16'h0000, led_q};
      TIMER_OFF:   rdata = timer_q;
      SCRATCH_OFF: rdata = scratch_q;
`ifdef SRAM_RESPONDER_STATS_EN
      RDCNT_OFF:   rdata = rdcnt_q;
      WRCNT_OFF:   rdata = wrcnt_q;
`endif
      default:     rdata = '0;
    endcase
  end

  assign led = led_q;

endmodule

// File: rtl/sram_responder.sv
// Memory-side responder for the CPU's instruction and data SRAM ports: shared RAM with
// byte-lane writes, 1-cycle registered reads, MMIO window (SRAM_RESPONDER_STATS_EN adds counters).
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int unsigned ADDR_W    = 14,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [31:0]       mem [Depth];
  logic [ADDR_W-1:0] inst_idx;
  logic [ADDR_W-1:0] data_idx;
  logic              inst_mmio;
  logic              data_mmio;
  logic              ram_wr;
  logic [31:0]       mmio_rdata;
  logic [31:0]       inst_rdata_q;
  logic [31:0]       data_rdata_q;

  assign inst_idx  = inst_sram_addr[ADDR_W+1:2];
  assign data_idx  = data_sram_addr[ADDR_W+1:2];
  assign inst_mmio = (inst_sram_addr[31:16] == MMIO_BASE[31:16]);
  assign data_mmio = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
  assign ram_wr    = data_sram_en & (|data_sram_wen) & ~data_mmio & ~reset;

  sram_responder_mmio u_mmio (
    .clk      (clk),
    .reset    (reset),
    .data_en  (data_sram_en),
    .mmio_sel (data_mmio),
    .wen      (data_sram_wen),
    .offset   (data_sram_addr[15:0]),
    .wdata    (data_sram_wdata),
    .rdata    (mmio_rdata),
    .led      (led)
  );

  // RAM is never reset; contents come from the simulation preload.
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      mem[data_idx] <= merge_bytes(mem[data_idx], data_sram_wdata, data_sram_wen);
    end
  end

  // Both ports sample the pre-write word, so same-word collisions return old data.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      if (inst_sram_en) inst_rdata_q <= inst_mmio ? 32'h0 : mem[inst_idx];
      if (data_sram_en) data_rdata_q <= data_mmio ? mmio_rdata : mem[data_idx];
    end
  end

  assign inst_sram_rdata = inst_rdata_q;
  assign data_sram_rdata = data_rdata_q;

  logic unused_sigs;
  assign unused_sigs = ^{inst_sram_wen, inst_sram_wdata, inst_sram_addr, data_sram_addr};

endmodule

// File: doc/sram_responder.md
# sram_responder

Memory-side responder for the CPU's two SRAM-style ports (instruction and data). It holds a shared word-organised RAM with byte-lane writes and returns read data exactly one cycle after each request, which is the fixed latency the pipeline expects. It also decodes a small MMIO window that provides an LED register, a free-running timer and a scratch register. It sits directly under the CPU top in the simulation and FPGA wrappers.

## Interface
Parameters:
- ADDR_W, 14: word-index width; the RAM depth is 2^ADDR_W 32-bit words.
- MMIO_BASE, 32'hBFAF_0000: base of the MMIO window; the match is on bits [31:16].

Ports:
- clk  in  1  single clock; all logic uses the rising edge.
- reset  in  1  synchronous reset, active-high.
- inst_sram_en  in  1  instruction-port request strobe.
- inst_sram_wen  in  4  byte write enables; ignored because the port is read-only.
- inst_sram_addr  in  32  byte address.
- inst_sram_wdata  in  32  ignored.
- inst_sram_rdata  out  32  read data, registered.
- data_sram_en  in  1  data-port request strobe.
- data_sram_wen  in  4  byte write enables; bit i writes byte i.
- data_sram_addr  in  32  byte address.
- data_sram_wdata  in  32  write data.
- data_sram_rdata  out  32  read data, registered.
- led  out  16  current LED register value.

## Operation
Address decode:
- Word index = addr[ADDR_W+1:2]. Higher bits alias, except when addr[31:16] == MMIO_BASE[31:16], which selects MMIO.
- addr[1:0] is ignored. Reads always return the full word.

RAM access:
- With en=1, the addressed word (or MMIO register) is captured into rdata at the edge.
- With en=1 and wen!=0 on the data port, only the enabled byte lanes are written at the same edge.
- Both ports are read-first: a data write reads back the old word.
- With en=0, rdata holds its previous value and no write occurs.

Port collision:
- A data write and an instruction read to the same word in the same cycle return the OLD word on inst_sram_rdata. The new value is visible from the next request onward.

MMIO map (offset = addr[15:0]):
- 0x0000 LED: read/write, byte-enabled on lanes 0–1; upper half reads 0.
- 0x0004 TIMER: read-only 32-bit counter. It increments every cycle that reset is low and wraps from FFFF_FFFF to 0. Writes are ignored.
- 0x0008 SCRATCH: read/write, byte-enabled.
- Any other offset reads 0; writes are dropped.

Instruction-port MMIO:
- Reads return 0. There are no side effects.

## Timing
- Read latency is 1 cycle: a request at edge N produces data valid after edge N, stable until the next enabled request on that port.
- A TIMER read at edge N returns the value held during the cycle before edge N, i.e. the pre-increment value.
- Write latency is 0 extra cycles: a write at edge N is visible to any read issued at edge N+1.
- Reset values: inst_sram_rdata=0, data_sram_rdata=0, led=0, TIMER=0, SCRATCH=0. RAM contents are not reset; they are preloaded by the simulation init.
- A request in a cycle with reset=1 is discarded: no write occurs and rdata stays 0.
- Reset asserted mid-stream clears all registers at that edge. The request on the first edge with reset low is served normally.

## Configuration
- SRAM_RESPONDER_STATS_EN defined: adds two 32-bit counters.
  - RDCNT at 0x0010 counts data-port reads (en=1, wen=0) that hit RAM or MMIO.
  - WRCNT at 0x0014 counts data-port writes (en=1, wen!=0).
  - Both saturate at FFFF_FFFF, reset to 0 and are read-only.
  - A read of RDCNT returns the count excluding itself.
- Not defined: 0x0010 and 0x0014 read 0, and no counter logic is built.

## Structure
- Package sram_responder_pkg: MMIO offset constants (LED_OFF, TIMER_OFF, SCRATCH_OFF, RDCNT_OFF, WRCNT_OFF) and the MMIO_BASE default.
- Sub-module sram_responder_mmio: holds the LED, TIMER, SCRATCH and optional counter registers, with its own decode and read mux.
- The top level holds the RAM array, byte-merge logic, port muxing and rdata registers.

## Test plan
- Reset, then data read of 0xBFAF0004 on the first edge with reset low, and again 5 cycles later -> data_sram_rdata = 0 then 5.
- Data write 0x0000_0100 with wdata=0xAABBCCDD and wen=4'b0101, then read the same address -> the read returns 0xXXBBXXDD. The old bytes are preserved; preload the word to 0x11223344 so the expected value is 0x11BB33DD.
- Same cycle: data write 0x12345678 to 0x200 and instruction read of 0x200 (preload 0) -> inst_sram_rdata = 0; an instruction read one cycle later returns 0x12345678.
- Write 0xFFFF_1234 to LED (wen=4'b1111) -> led = 16'h1234; the readback returns 0x0000_1234. Then assert reset for 1 cycle -> led = 0.
- Write to TIMER and to undefined offset 0x0020, then read both -> the timer continues counting unaffected and 0x0020 reads 0.
- With SRAM_RESPONDER_STATS_EN: 3 data reads and 2 data writes, then read 0x0014 and 0x0010 -> 2 and 4. The extra read counted is the 0x0014 read; the 0x0010 read excludes itself.
